// File: rtl/alu_byte_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_byte_sched_if
// Description : Byte-wide ALU bus between the scheduler (master) and the
//               shared combinational 8-bit ALU (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_byte_sched_if;
    logic [6:0] alu_cmd;
    logic [7:0] alu_inA;
    logic [7:0] alu_inB;
    logic       alu_sc_i;
    logic [7:0] alu_rslt;
    logic       alu_sc_o;

    modport master (
        output alu_cmd, alu_inA, alu_inB, alu_sc_i,
        input  alu_rslt, alu_sc_o
    );

    modport slave (
        input  alu_cmd, alu_inA, alu_inB, alu_sc_i,
        output alu_rslt, alu_sc_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_byte_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_byte_sched
// Description : Round-robin scheduler sharing one 8-bit ALU between two
//               requesters; runs 8..32-bit ops one byte slice per cycle with
//               the shift/carry bit chained between slices.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_byte_sched #(
    parameter int NREQ = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [NREQ-1:0] req,
    input  wire logic [2:0]      op0,
    input  wire logic [2:0]      op1,
    input  wire logic [1:0]      len0,
    input  wire logic [1:0]      len1,
    input  wire logic [31:0]     a0,
    input  wire logic [31:0]     b0,
    input  wire logic [31:0]     a1,
    input  wire logic [31:0]     b1,
    output logic      [NREQ-1:0] gnt,
    output logic      [NREQ-1:0] done,
    output logic      [31:0]     rslt,
    output logic                 cout,
    output logic                 zero,
    output logic                 busy,
    alu_byte_sched_if.master     alu
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [3:0] CMD_LO = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q,  last_d;
    logic [2:0]  op_q,    op_d;
    logic [1:0]  len_q,   len_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [1:0]  idx_q,   idx_d;
    logic        carry_q, carry_d;
    logic [31:0] acc_q,   acc_d;
    logic [31:0] rslt_q,  rslt_d;
    logic        cout_q,  cout_d;
    logic        zero_q,  zero_d;

    logic        win;
    logic        op_valid;
    logic        is_srl;
    logic        last_byte;
    logic        carry_nxt;
    logic [7:0]  slice_a;
    logic [7:0]  slice_b;
    logic [7:0]  byte_res;

    assign rslt = rslt_q;
    assign cout = cout_q;
    assign zero = zero_q;
    assign busy = (state_q != ST_IDLE);

    // State register and datapath flops; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= 3'd0;
            len_q   <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            acc_q   <= 32'd0;
            rslt_q  <= 32'd0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            len_q   <= len_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            rslt_q  <= rslt_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    // Arbitration, byte-slice sequencing and ALU drive.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        op_d      = op_q;
        len_d     = len_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        acc_d     = acc_q;
        rslt_d    = rslt_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        gnt       = '0;
        done      = '0;
        win       = 1'b0;
        op_valid  = (op_q <= OP_SRL);
        is_srl    = (op_q == OP_SRL);
        last_byte = 1'b0;
        carry_nxt = 1'b0;
        slice_a   = 8'd0;
        slice_b   = 8'd0;
        byte_res  = 8'd0;
        alu.alu_cmd  = 7'd0;
        alu.alu_inA  = 8'd0;
        alu.alu_inB  = 8'd0;
        alu.alu_sc_i = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst_n gating keeps gnt low while reset is held.
                if (rst_n && (req[0] || req[1])) begin
                    // Tie goes to whoever was not served last.
                    win     = (req[0] && req[1]) ? ~last_q : req[1];
                    gnt[0]  = ~win;
                    gnt[1]  = win;
                    owner_d = win;
                    last_d  = win;
                    op_d    = win ? op1  : op0;
                    len_d   = win ? len1 : len0;
                    a_d     = win ? a1   : a0;
                    b_d     = win ? b1   : b0;
                    acc_d   = 32'd0;
                    carry_d = 1'b0;
                    // srl walks from the MSB byte down so the shifted-out bit
                    // of a higher byte lands in bit 7 of the next lower one.
                    idx_d   = ((win ? op1 : op0) == OP_SRL) ? (win ? len1 : len0) : 2'd0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                for (int i = 0; i < 4; i++) begin
                    if (idx_q == 2'(i)) begin
                        slice_a = a_q[i*8 +: 8];
                        slice_b = b_q[i*8 +: 8];
                    end
                end
                alu.alu_cmd  = op_valid ? {op_q, CMD_LO} : 7'd0;
                alu.alu_inA  = slice_a;
                alu.alu_inB  = slice_b;
                alu.alu_sc_i = carry_q;
                byte_res     = op_valid ? alu.alu_rslt : 8'd0;
                // Only add and srl propagate a chain bit.
                carry_nxt    = ((op_q == OP_ADD) || is_srl) ? alu.alu_sc_o : 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (idx_q == 2'(i)) begin
                        acc_d[i*8 +: 8] = byte_res;
                    end
                end
                carry_d   = carry_nxt;
                last_byte = is_srl ? (idx_q == 2'd0) : (idx_q == len_q);
                if (last_byte) begin
                    // Bytes above len stay zero, so the full-word NOR is
                    // the NOR of the valid bytes.
                    rslt_d  = acc_d;
                    cout_d  = carry_nxt;
                    zero_d  = ~|acc_d;
                    state_d = ST_DONE;
                end else begin
                    idx_d = is_srl ? (idx_q - 2'd1) : (idx_q + 2'd1);
                end
            end

            ST_DONE: begin
                done[0] = ~owner_q;
                done[1] = owner_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_byte_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_byte_sched
// Description : Scoreboard bench for alu_byte_sched with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_byte_sched;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;

    typedef struct {
        logic        owner;
        int          done_cyc;
        logic [33:0] res;      // {zero, cout, rslt}
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [2:0]  op0, op1;
    logic [1:0]  len0, len1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt, done;
    logic [31:0] rslt;
    logic        cout, zero, busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        tb_last = 1'b1;
    exp_t        sb[$];
    int          gnt_cyc_log[$];
    logic        gnt_own_log[$];
    logic [7:0]  log_a[$];
    logic        log_sc[$];
    logic [6:0]  log_cmd[$];

    alu_byte_sched_if aif ();

    alu_byte_sched #(.NREQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op0   (op0),
        .op1   (op1),
        .len0  (len0),
        .len1  (len1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .gnt   (gnt),
        .done  (done),
        .rslt  (rslt),
        .cout  (cout),
        .zero  (zero),
        .busy  (busy),
        .alu   (aif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 8-bit ALU: commands are {op, 4'b0100}; anything else idles.
    always_comb begin
        aif.alu_rslt = 8'd0;
        aif.alu_sc_o = 1'b0;
        if (aif.alu_cmd[3:0] == 4'b0100) begin
            case (aif.alu_cmd[6:4])
                OP_ADD:  {aif.alu_sc_o, aif.alu_rslt} = {1'b0, aif.alu_inA} + {1'b0, aif.alu_inB} + {8'd0, aif.alu_sc_i};
                OP_XOR:  aif.alu_rslt = aif.alu_inA ^ aif.alu_inB;
                OP_OR:   aif.alu_rslt = aif.alu_inA | aif.alu_inB;
                OP_AND:  aif.alu_rslt = aif.alu_inA & aif.alu_inB;
                OP_SRL: begin
                    aif.alu_rslt = {aif.alu_sc_i, aif.alu_inA[7:1]};
                    aif.alu_sc_o = aif.alu_inA[0];
                end
                default: aif.alu_rslt = 8'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Whole-word reference of the operation on the low len+1 bytes.
    function automatic logic [33:0] model(input logic [2:0] op, input logic [1:0] len,
                                          input logic [31:0] a, input logic [31:0] b);
        int          nbits;
        logic [63:0] m, am, bm, s, r;
        logic        c;
        nbits = 8 * (int'(len) + 1);
        m  = (64'd1 << nbits) - 64'd1;
        am = {32'd0, a} & m;
        bm = {32'd0, b} & m;
        s  = 64'd0;
        r  = 64'd0;
        c  = 1'b0;
        case (op)
            OP_ADD: begin s = am + bm; r = s & m; c = s[nbits]; end
            OP_XOR: r = am ^ bm;
            OP_OR:  r = am | bm;
            OP_AND: r = am & bm;
            OP_SRL: begin r = am >> 1; c = am[0]; end
            default: r = 64'd0;
        endcase
        return {(r == 64'd0), c, r[31:0]};
    endfunction

    // Arbitration model and scoreboard; samples on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic w;
        if (!rst_n) begin
            tb_last = 1'b1;
            sb.delete();
        end else begin
            if (gnt != 2'b00) begin
                w = (req[0] && req[1]) ? ~tb_last : req[1];
                chk("gnt_owner", {62'd0, gnt}, w ? 64'd2 : 64'd1);
                chk("gnt_busy", {63'd0, busy}, 64'd0);
                tb_last    = w;
                e.owner    = w;
                e.done_cyc = cyc + int'(w ? len1 : len0) + 2;
                e.res      = w ? model(op1, len1, a1, b1) : model(op0, len0, a0, b0);
                sb.push_back(e);
                gnt_cyc_log.push_back(cyc);
                gnt_own_log.push_back(w);
            end else if (!busy && req != 2'b00) begin
                chk("gnt_missing", {62'd0, gnt}, {62'd0, req});
            end
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", {62'd0, done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_owner", {62'd0, done}, e.owner ? 64'd2 : 64'd1);
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    chk("rslt", {32'd0, rslt}, {32'd0, e.res[31:0]});
                    chk("cout", {63'd0, cout}, {63'd0, e.res[32]});
                    chk("zero", {63'd0, zero}, {63'd0, e.res[33]});
                    chk("busy_done", {63'd0, busy}, 64'd1);
                end
            end else if (busy) begin
                log_a.push_back(aif.alu_inA);
                log_sc.push_back(aif.alu_sc_i);
                log_cmd.push_back(aif.alu_cmd);
            end
        end
    end

    task automatic clear_logs();
        log_a.delete();
        log_sc.delete();
        log_cmd.delete();
    endtask

    task automatic issue(input logic r, input logic [2:0] op, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] b);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (!r) begin op0 = op; len0 = len; a0 = a; b0 = b; req[0] = 1'b1; end
        else    begin op1 = op; len1 = len; a1 = a; b1 = b; req[1] = 1'b1; end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt[r]) begin got = 1'b1; break; end
        end
        if (!got) chk("gnt_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req[r] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  {62'd0, gnt},  64'd0);
        chk({tag, "_done"}, {62'd0, done}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_rslt"}, {32'd0, rslt}, 64'd0);
        chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
        chk({tag, "_zero"}, {63'd0, zero}, 64'd0);
        chk({tag, "_alu"},  {39'd0, aif.alu_cmd, aif.alu_inA, aif.alu_inB, aif.alu_sc_i}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        op0 = 3'd0; op1 = 3'd0; len0 = 2'd0; len1 = 2'd0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk); #2 rst_n = 1'b1;

        // 16-bit add carrying into byte 1
        clear_logs();
        issue(1'b0, OP_ADD, 2'd1, 32'h0000_00FF, 32'h0000_0001);
        wait_idle();
        chk("add16_cmd", {57'd0, log_cmd[0]}, 64'h04);

        // 16-bit srl: MSB byte first, shifted bit chained downward
        clear_logs();
        issue(1'b0, OP_SRL, 2'd1, 32'h0000_0181, 32'h0);
        wait_idle();
        chk("srl_nbytes", 64'(log_a.size()), 64'd2);
        chk("srl_inA0", {56'd0, log_a[0]}, 64'h01);
        chk("srl_inA1", {56'd0, log_a[1]}, 64'h81);

        // 32-bit add rippling a carry through every byte
        clear_logs();
        issue(1'b1, OP_ADD, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_idle();
        chk("add32_nbytes", 64'(log_sc.size()), 64'd4);
        chk("add32_sc0", {63'd0, log_sc[0]}, 64'd0);
        chk("add32_sc1", {63'd0, log_sc[1]}, 64'd1);
        chk("add32_sc2", {63'd0, log_sc[2]}, 64'd1);
        chk("add32_sc3", {63'd0, log_sc[3]}, 64'd1);

        // Both requesters held: grants alternate, 3 cycles apart for 8-bit ops
        gnt_cyc_log.delete();
        gnt_own_log.delete();
        @(posedge clk); #1;
        op0 = OP_XOR; len0 = 2'd0; a0 = 32'h0000_005A; b0 = 32'h0000_000F;
        op1 = OP_XOR; len1 = 2'd0; a1 = 32'h0000_00F0; b1 = 32'h0000_00FF;
        req = 2'b11;
        for (int k = 0; k < 60 && gnt_cyc_log.size() < 4; k++) @(negedge clk);
        @(posedge clk); #1;
        req = 2'b00;
        wait_idle();
        chk("tie_count", 64'(gnt_cyc_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < gnt_cyc_log.size(); i++) begin
            chk("tie_owner", {63'd0, gnt_own_log[i]}, 64'(i % 2));
            if (i > 0) chk("tie_spacing", 64'(gnt_cyc_log[i] - gnt_cyc_log[i-1]), 64'd3);
        end

        // Invalid op: same latency, ALU idle, zero result
        clear_logs();
        issue(1'b1, 3'b110, 2'd2, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle();
        chk("inv_nbytes", 64'(log_cmd.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("inv_cmd", {57'd0, log_cmd[i]}, 64'd0);

        // Logic ops and edge widths: upper bytes must read back as zero
        issue(1'b1, OP_OR,  2'd1, 32'hFFFF_1234, 32'h00F0_0001); wait_idle();
        issue(1'b0, OP_SRL, 2'd3, 32'h8000_0003, 32'h0);         wait_idle();
        issue(1'b0, OP_ADD, 2'd0, 32'hAAAA_AAFF, 32'h5555_5502); wait_idle();
        issue(1'b0, OP_AND, 2'd2, 32'h12FF_00FF, 32'hFFF0_F00F); wait_idle();

        // Reset during RUN byte 1 of a 32-bit add
        @(posedge clk); #1;
        op0 = OP_ADD; len0 = 2'd3; a0 = 32'h0101_0101; b0 = 32'h0202_0202; req[0] = 1'b1;
        @(negedge clk);
        chk("rst_pre_gnt", {62'd0, gnt}, 64'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        @(negedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) @(negedge clk);
        chk("rst_no_done_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        op1 = OP_XOR; len1 = 2'd0; a1 = 32'h0000_0033; b1 = 32'h0000_0011; req[1] = 1'b1;
        @(negedge clk);
        chk("rst_first_gnt1", {62'd0, gnt}, 64'd2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_idle();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
